// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock, key schedule
// expanded on the fly alongside the data path.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request to encrypt; sampled only while idle
//   key    128-bit cipher key, captured with an accepted start
//   in     128-bit plaintext, captured with an accepted start
//   out    128-bit ciphertext, updated only on the done edge
//   busy   high while rounds are in progress
//   done   one-cycle pulse when out is updated
//
// Byte order is FIPS-197 column-major: bits [127:120] are byte 0 (row 0, col 0).
module aes128_encrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e       fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic [127:0] nk, sb, sr, mc;
  logic [31:0]  rot_w, sub_w, w0, w1, w2, w3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (x^254 in GF(2^8)) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gmul(b, b);
    x3   = gmul(x2, b);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    inv  = gmul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] a);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(a[127-8*i -: 8]);
    return o;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] a);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = a[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] a);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = a[127-32*c -: 8];
      a1 = a[119-32*c -: 8];
      a2 = a[111-32*c -: 8];
      a3 = a[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Key schedule: next round key from the current one.
  always_comb begin
    rot_w = {rk_q[23:0], rk_q[31:24]};
    sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    w0    = rk_q[127:96] ^ sub_w ^ {rcon_q, 24'h000000};
    w1    = rk_q[95:64] ^ w0;
    w2    = rk_q[63:32] ^ w1;
    w3    = rk_q[31:0] ^ w2;
    nk    = {w0, w1, w2, w3};
  end

  // Round data path; the last round skips MixColumns.
  always_comb begin
    sb = sub_bytes(state_q);
    sr = shift_rows(sb);
    mc = (round_q == 4'd10) ? sr : mix_columns(sr);
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    out_d   = out_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (start) begin
          state_d = in ^ key;
          rk_d    = key;
          round_d = 4'd1;
          rcon_d  = 8'h01;
          fsm_d   = StRun;
        end
      end
      StRun: begin
        state_d = mc ^ nk;
        rk_d    = nk;
        round_d = round_q + 4'd1;
        rcon_d  = xtime(rcon_q);
        if (round_q == 4'd10) begin
          out_d  = sr ^ nk;
          done_d = 1'b1;
          fsm_d  = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      rk_q    <= '0;
      out_q   <= '0;
      round_q <= '0;
      rcon_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      out_q   <= out_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (fsm_q == StRun);
  assign done = done_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter: table-driven AES reference model,
// a transaction-level timing model, a per-cycle compare process and directed vectors.
module tb_aes128_encrypt_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] pt = '0;
  logic [127:0] out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes128_encrypt_iter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .key  (key),
    .in   (pt),
    .out  (out),
    .busy (busy),
    .done (done)
  );

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047-8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Textbook AES-128: full key expansion up front, byte-array state.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p,
                                           output logic [127:0] r1);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, t0, a0, a1, a2, a3;
    logic [127:0] res;
    r1 = '0;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        t0     = tmp[0];
        tmp[0] = sb(tmp[1]) ^ rc;
        tmp[1] = sb(tmp[2]);
        tmp[2] = sb(tmp[3]);
        tmp[3] = sb(t0);
        rc     = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
      if (r == 1) for (int i = 0; i < 16; i++) r1[127-8*i -: 8] = s[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: a block is accepted while idle and its result appears
  // with a done pulse ten cycles later; a reset drops everything.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_cnt = 0;
  logic [127:0] m_out = '0;
  logic [127:0] m_res = '0;
  logic [127:0] m_dummy;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_out = '0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_cnt  = 1;
          m_res  = aes_ref(key, pt, m_dummy);
        end
      end else if (m_cnt == 10) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_out  = m_res;
      end else begin
        m_cnt++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_out", out, m_out);
    chk("cyc_busy", {127'b0, busy}, {127'b0, m_busy});
    chk("cyc_done", {127'b0, done}, {127'b0, m_done});
  end

  // Drives start now (caller sits at a negedge); junk bits assert ignored starts with
  // random operands. Returns at the negedge where done is seen.
  task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                           input logic [31:0] junk, input logic [127:0] exp,
                           input logic [127:0] prev, output logic [127:0] st1);
    int lat;
    lat   = -1;
    st1   = '0;
    start = 1'b1;
    key   = k;
    pt    = p;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (junk[n]) begin
        start = 1'b1;
        key   = {$urandom, $urandom, $urandom, $urandom};
        pt    = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      if (n == 1) chk("busy_after_start", {127'b0, busy}, 128'd1);
      if (n == 2) st1 = dut.state_q;
      if (done) begin
        lat = n;
        break;
      end
      chk("out_held", out, prev);
    end
    start = 1'b0;
    chk("done_latency", 128'(lat), 128'd11);
    chk("ciphertext", out, exp);
  endtask

  initial begin
    logic [127:0] r1, s1;
    int           n_done;
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] r1, s1;
    int           n_done;

    repeat (2) @(negedge clk);
    chk("reset_out", out, 128'h0);
    chk("reset_busy", {127'b0, busy}, 128'd0);
    chk("reset_done", {127'b0, done}, 128'd0);
    chk("model_c1", aes_ref(C1_KEY, C1_PT, r1), C1_CT);
    chk("model_b", aes_ref(B_KEY, B_PT, r1), B_CT);
    chk("model_b_r1", r1, B_R1);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1
    run_block(C1_KEY, C1_PT, 32'h0, C1_CT, 128'h0, s1);
    repeat (3) @(negedge clk);

    // FIPS-197 Appendix B, including the state after round 1
    run_block(B_KEY, B_PT, 32'h0, B_CT, C1_CT, s1);
    chk("b_round1_state", s1, B_R1);
    repeat (2) @(negedge clk);

    // Starts at cycles 3 and 7 while busy are dropped
    run_block(C1_KEY, C1_PT, 32'h88, C1_CT, B_CT, s1);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("busy_start_extra_done", 128'(n_done), 128'd0);
    chk("busy_start_idle", {127'b0, busy}, 128'd0);

    // Back-to-back: B is started in the done cycle of C.1
    run_block(C1_KEY, C1_PT, 32'h0, C1_CT, C1_CT, s1);
    run_block(B_KEY, B_PT, 32'h0, B_CT, C1_CT, s1);
    repeat (2) @(negedge clk);

    // Asynchronous reset during round 5
    start = 1'b1; key = C1_KEY; pt = C1_PT;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out", out, 128'h0);
    chk("abort_busy", {127'b0, busy}, 128'd0);
    chk("abort_done", {127'b0, done}, 128'd0);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      if (done) n_done++;
    end
    chk("abort_no_done", 128'(n_done), 128'd0);
    run_block(C1_KEY, C1_PT, 32'h0, C1_CT, 128'h0, s1);

    // Hold: no start for 50 cycles while operands toggle
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      if (done || busy) n_done++;
    end
    chk("hold_quiet", 128'(n_done), 128'd0);
    chk("hold_out", out, C1_CT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
